// File: rtl/data_sram_responder.sv
// Responder for the data_sram interface: word-organised storage with a one-cycle
// registered read, a one-entry coalescing write buffer and a sticky range error.
module data_sram_responder #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          DEPTH = 1024,
  parameter int          IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  logic [31:0]      rdata_q, rdata_d;
  logic             addr_err_q, addr_err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic             buf_v_q, buf_v_d;
  logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
  logic [3:0]       buf_str_q, buf_str_d;
  logic [31:0]      buf_data_q, buf_data_d;

  logic [31:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             is_write;
  logic             hit;
  logic             commit_en;

  // Offset compare avoids overflow when BASE + SPAN wraps past 2^32.
  assign off      = data_sram_addr - BASE;
  assign in_range = (data_sram_addr >= BASE) && (off < SPAN);
  assign idx      = off[IDX_W+1:2];
  assign is_write = |data_sram_wen;
  assign hit      = buf_v_q && (buf_idx_q == idx);

  always_comb begin
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q;
    err_addr_d = err_addr_q;
    buf_v_d    = buf_v_q;
    buf_idx_d  = buf_idx_q;
    buf_str_d  = buf_str_q;
    buf_data_d = buf_data_q;
    commit_en  = 1'b0;

    if (!data_sram_en) begin
      commit_en = buf_v_q;
      buf_v_d   = 1'b0;
    end else if (!in_range) begin
      rdata_d = 32'h0;
      if (!addr_err_q) begin
        addr_err_d = 1'b1;
        err_addr_d = data_sram_addr;
      end
    end else if (!is_write) begin
      // Pending buffered bytes are newer than the array, so they win per lane.
      rdata_d = mem[idx];
      for (int k = 0; k < 4; k++) begin
        if (hit && buf_str_q[k]) rdata_d[8*k +: 8] = buf_data_q[8*k +: 8];
      end
    end else if (hit) begin
      for (int k = 0; k < 4; k++) begin
        if (data_sram_wen[k]) buf_data_d[8*k +: 8] = data_sram_wdata[8*k +: 8];
      end
      buf_str_d = buf_str_q | data_sram_wen;
    end else begin
      commit_en  = buf_v_q;
      buf_v_d    = 1'b1;
      buf_idx_d  = idx;
      buf_str_d  = data_sram_wen;
      buf_data_d = data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
      err_addr_q <= 32'h0;
      buf_v_q    <= 1'b0;
      buf_idx_q  <= '0;
      buf_str_q  <= 4'h0;
      buf_data_q <= 32'h0;
    end else begin
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
      err_addr_q <= err_addr_d;
      buf_v_q    <= buf_v_d;
      buf_idx_q  <= buf_idx_d;
      buf_str_q  <= buf_str_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Array is not reset; buf_v_q clears asynchronously so no commit happens in reset.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      for (int k = 0; k < 4; k++) begin
        if (buf_str_q[k]) mem[buf_idx_q][8*k +: 8] <= buf_data_q[8*k +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign addr_err        = addr_err_q;
  assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: reset, buffered writes, coalescing,
// commit ordering, range errors and reset discarding a pending store.
module tb_data_sram_responder;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        addr_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  data_sram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .addr_err        (addr_err),
    .err_addr        (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    step(1'b1, wen, addr, wdata);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst             = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_rdata",    data_sram_rdata, 32'h0);
    check("reset_addr_err", {31'h0, addr_err}, 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    rst = 1'b1;

    // Preload words used later.
    wr(32'h0000_0010, 4'hF, 32'h0123_4567);
    wr(32'h0000_0000, 4'hF, 32'h5A5A_5A5A);
    idle();
    rd(32'h0000_0010);
    check("read_0x10", data_sram_rdata, 32'h0123_4567);
    check("read_0x10_no_err", {31'h0, addr_err}, 32'h0);

    // Write holds rdata; immediate read is served from the buffer.
    wr(32'h0000_0020, 4'hF, 32'hDEAD_BEEF);
    check("write_holds_rdata", data_sram_rdata, 32'h0123_4567);
    rd(32'h0000_0020);
    check("raw_0x20", data_sram_rdata, 32'hDEAD_BEEF);

    // Coalescing into the same word.
    wr(32'h0000_0020, 4'hF, 32'h0000_0000);
    wr(32'h0000_0020, 4'b0001, 32'h0000_00AA);
    wr(32'h0000_0020, 4'b1000, 32'hBB00_0000);
    idle();
    rd(32'h0000_0020);
    check("coalesce_0x20", data_sram_rdata, 32'hBB00_00AA);

    // New write to another word commits the old buffer.
    wr(32'h0000_0030, 4'hF, 32'h1111_1111);
    wr(32'h0000_0034, 4'hF, 32'h2222_2222);
    rd(32'h0000_0030);
    check("commit_0x30", data_sram_rdata, 32'h1111_1111);
    rd(32'h0000_0034);
    check("buffer_0x34", data_sram_rdata, 32'h2222_2222);

    // Partial coalesce, merged lane on readback.
    wr(32'h0000_0034, 4'b0100, 32'h0055_0000);
    rd(32'h0000_0034);
    check("partial_merge_0x34", data_sram_rdata, 32'h2255_2222);

    // Last in-range word.
    wr(32'h0000_0FFC, 4'hF, 32'hA5A5_A5A5);
    rd(32'h0000_0FFC);
    check("last_word", data_sram_rdata, 32'hA5A5_A5A5);
    check("last_word_no_err", {31'h0, addr_err}, 32'h0);

    // First out-of-range address.
    rd(32'h0000_1000);
    check("oor_rdata", data_sram_rdata, 32'h0);
    check("oor_addr_err", {31'h0, addr_err}, 32'h1);
    check("oor_err_addr", err_addr, 32'h0000_1000);

    // Second error does not overwrite; 0x2000 would alias word 0 if unchecked.
    wr(32'h0000_2000, 4'hF, 32'h9999_9999);
    check("oor2_err_addr", err_addr, 32'h0000_1000);
    check("oor2_addr_err", {31'h0, addr_err}, 32'h1);
    rd(32'h0000_0000);
    check("oor2_no_alias", data_sram_rdata, 32'h5A5A_5A5A);
    rd(32'h0000_0FFC);
    check("oor2_buffer_kept", data_sram_rdata, 32'hA5A5_A5A5);
    idle();
    rd(32'h0000_0034);
    check("committed_0x34", data_sram_rdata, 32'h2255_2222);

    // Reset discards a pending buffered store.
    wr(32'h0000_0040, 4'hF, 32'h0BAD_C0DE);
    idle();
    wr(32'h0000_0040, 4'hF, 32'hCAFE_F00D);
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset_rdata",    data_sram_rdata, 32'h0);
    check("midreset_addr_err", {31'h0, addr_err}, 32'h0);
    check("midreset_err_addr", err_addr, 32'h0);
    rst = 1'b1;
    rd(32'h0000_0040);
    check("discarded_0x40", data_sram_rdata, 32'h0BAD_C0DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
